// File: rtl/vga_text_ram_arbiter.sv
// Single-port text RAM arbiter: display fetch has absolute priority, then the
// clear-screen sequencer, then the CPU request/acknowledge port.
module vga_text_ram_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int NUM_CELLS = 2000
) (
  input  logic              pixel_clk,
  input  logic              data_reset_n,
  input  logic              disp_fetch,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_WAIT,
    CPU_ACK,
    CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_CELLS - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] clrPtr_q;
  logic [ADDR_W-1:0] clrPtr_d;
  logic [DATA_W-1:0] fill_q;
  logic              clrPend_q;
  logic              cpuWe_q;
  logic              cpuOor_q;
  logic              fetch_q;
  logic [DATA_W-1:0] dispData_q;
  logic              dispValid_q;
  logic [DATA_W-1:0] cpuRdata_q;
  logic              cpuAck_q;
  logic              cpuErr_q;
  logic              clrBusy_q;

  logic cpuOor;
  logic dispGrant;
  logic clrGrant;
  logic cpuGrant;

  // Grants are gated by reset so the RAM port is quiet while reset is held.
  always_comb begin
    cpuOor    = ({{(32-ADDR_W){1'b0}}, cpu_addr} >= 32'(NUM_CELLS));
    dispGrant = data_reset_n && disp_fetch;
    clrGrant  = data_reset_n && !disp_fetch && (state_q == CLEAR);
    cpuGrant  = data_reset_n && !disp_fetch && (state_q == IDLE) &&
                cpu_req && !cpuAck_q && !clr_start;
    clrPtr_d  = clrPtr_q + 1'b1;

    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (dispGrant) begin
      ram_addr = disp_addr;
    end else if (clrGrant) begin
      ram_addr  = clrPtr_q;
      ram_wdata = fill_q;
      ram_we    = 1'b1;
    end else if (cpuGrant) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we && !cpuOor;
    end
  end

  always_ff @(posedge pixel_clk or negedge data_reset_n) begin
    if (!data_reset_n) begin
      state_q     <= IDLE;
      clrPtr_q    <= '0;
      fill_q      <= '0;
      clrPend_q   <= 1'b0;
      cpuWe_q     <= 1'b0;
      cpuOor_q    <= 1'b0;
      fetch_q     <= 1'b0;
      dispData_q  <= '0;
      dispValid_q <= 1'b0;
      cpuRdata_q  <= '0;
      cpuAck_q    <= 1'b0;
      cpuErr_q    <= 1'b0;
      clrBusy_q   <= 1'b0;
    end else begin
      fetch_q     <= disp_fetch;
      dispValid_q <= fetch_q;
      if (fetch_q) begin
        dispData_q <= ram_rdata;
      end
      cpuAck_q <= 1'b0;
      cpuErr_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (clr_start) begin
            state_q   <= CLEAR;
            clrBusy_q <= 1'b1;
            clrPtr_q  <= '0;
            fill_q    <= clr_value;
          end else if (cpuGrant) begin
            state_q  <= CPU_WAIT;
            cpuWe_q  <= cpu_we;
            cpuOor_q <= cpuOor;
          end
        end
        CPU_WAIT: begin
          cpuRdata_q <= (!cpuWe_q && !cpuOor_q) ? ram_rdata : '0;
          cpuErr_q   <= cpuOor_q;
          cpuAck_q   <= 1'b1;
          state_q    <= CPU_ACK;
          // A clear requested mid-access is remembered and started after the ack.
          if (clr_start) begin
            clrPend_q <= 1'b1;
            fill_q    <= clr_value;
          end
        end
        CPU_ACK: begin
          if (clrPend_q || clr_start) begin
            state_q   <= CLEAR;
            clrBusy_q <= 1'b1;
            clrPtr_q  <= '0;
            clrPend_q <= 1'b0;
            if (!clrPend_q) begin
              fill_q <= clr_value;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CLEAR: begin
          if (clrGrant) begin
            clrPtr_q <= clrPtr_d;
            if (clrPtr_q == LAST_CELL) begin
              state_q   <= IDLE;
              clrBusy_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign disp_data  = dispData_q;
  assign disp_valid = dispValid_q;
  assign cpu_rdata  = cpuRdata_q;
  assign cpu_ack    = cpuAck_q;
  assign cpu_err    = cpuErr_q;
  assign clr_busy   = clrBusy_q;

endmodule

// File: tb/tb_vga_text_ram_arbiter.sv
// Directed bench for vga_text_ram_arbiter: per-cycle vector table plus
// hand-written clear, priority and reset sequences against a synchronous RAM model.
module tb_vga_text_ram_arbiter;

  logic        pixel_clk;
  logic        data_reset_n;
  logic        disp_fetch;
  logic [11:0] disp_addr;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        cpu_err;
  logic        clr_start;
  logic [15:0] clr_value;
  logic        clr_busy;
  logic [11:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;

  logic [15:0] mem [0:4095];

  int testsRun;
  int testsFailed;

  typedef struct {
    logic        dispFetch;
    logic [11:0] dispAddr;
    logic        cpuReq;
    logic        cpuWe;
    logic [11:0] cpuAddr;
    logic [15:0] cpuWdata;
    logic        expWe;
    logic [11:0] expAddr;
    logic [15:0] expWdata;
    logic        expAck;
    logic        expErr;
    logic [15:0] expRdata;
    logic        expValid;
    logic [15:0] expDispData;
  } vec_t;

  vec_t vecs[$];

  vga_text_ram_arbiter #(
    .ADDR_W(12),
    .DATA_W(16),
    .NUM_CELLS(2000)
  ) dut (
    .pixel_clk(pixel_clk),
    .data_reset_n(data_reset_n),
    .disp_fetch(disp_fetch),
    .disp_addr(disp_addr),
    .disp_data(disp_data),
    .disp_valid(disp_valid),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err),
    .clr_start(clr_start),
    .clr_value(clr_value),
    .clr_busy(clr_busy),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  // Synchronous RAM model; reset reloads the pattern A000+address.
  always @(posedge pixel_clk or negedge data_reset_n) begin
    if (!data_reset_n) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'hA000 + 16'(i);
      ram_rdata <= '0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(logic df, logic [11:0] da, logic rq, logic we,
                              logic [11:0] ca, logic [15:0] wd, logic eWe,
                              logic [11:0] eA, logic [15:0] eWd, logic eAck,
                              logic eErr, logic [15:0] eRd, logic eV,
                              logic [15:0] eDd);
    vec_t v;
    v.dispFetch = df;  v.dispAddr = da;   v.cpuReq = rq;     v.cpuWe = we;
    v.cpuAddr = ca;    v.cpuWdata = wd;   v.expWe = eWe;     v.expAddr = eA;
    v.expWdata = eWd;  v.expAck = eAck;   v.expErr = eErr;   v.expRdata = eRd;
    v.expValid = eV;   v.expDispData = eDd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge pixel_clk);
    disp_fetch = v.dispFetch;
    disp_addr  = v.dispAddr;
    cpu_req    = v.cpuReq;
    cpu_we     = v.cpuWe;
    cpu_addr   = v.cpuAddr;
    cpu_wdata  = v.cpuWdata;
    clr_start  = 1'b0;
  endtask

  task automatic runClear(input logic [15:0] value, input bit inject, input int expBusy);
    int busyCount;
    int writeCount;
    int badWrites;
    int badCells;
    busyCount = 0; writeCount = 0; badWrites = 0; badCells = 0;
    @(negedge pixel_clk);
    clr_start = 1'b1;
    clr_value = value;
    #1;
    checkOutput("clr start cycle busy", 32'(clr_busy), 32'd0);
    @(negedge pixel_clk);
    clr_start = 1'b0;
    clr_value = 16'hFFFF;
    for (int k = 0; k < 3000; k++) begin
      disp_fetch = inject && (k % 8 == 0);
      disp_addr  = 12'h050;
      #1;
      if (!clr_busy) break;
      busyCount++;
      if (ram_we) begin
        if (ram_addr != 12'(writeCount) || ram_wdata != value) badWrites++;
        writeCount++;
      end else if (!disp_fetch) begin
        badWrites++;
      end
      @(negedge pixel_clk);
    end
    disp_fetch = 1'b0;
    for (int i = 0; i < 2000; i++) if (mem[i] != value) badCells++;
    checkOutput("clr busy cycles", 32'(busyCount), 32'(expBusy));
    checkOutput("clr write count", 32'(writeCount), 32'd2000);
    checkOutput("clr bad writes", 32'(badWrites), 32'd0);
    checkOutput("clr bad cells", 32'(badCells), 32'd0);
    checkOutput("clr cell 2000 untouched", 32'(mem[2000]), 32'h0000A7D0);
  endtask

  initial begin
    int validCount;
    int busyCount;
    int acks;
    int badFill;
    testsRun = 0;
    testsFailed = 0;
    data_reset_n = 1'b1;
    disp_fetch = 0; disp_addr = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0;
    cpu_wdata = 0; clr_start = 0; clr_value = 0;

    // Reset held with a pending CPU read: every output must stay at zero.
    #2;
    data_reset_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h003;
    repeat (3) @(negedge pixel_clk);
    #1;
    checkOutput("rst ram_we", 32'(ram_we), 0);
    checkOutput("rst ram_addr", 32'(ram_addr), 0);
    checkOutput("rst ram_wdata", 32'(ram_wdata), 0);
    checkOutput("rst cpu_ack", 32'(cpu_ack), 0);
    checkOutput("rst cpu_err", 32'(cpu_err), 0);
    checkOutput("rst cpu_rdata", 32'(cpu_rdata), 0);
    checkOutput("rst disp_valid", 32'(disp_valid), 0);
    checkOutput("rst disp_data", 32'(disp_data), 0);
    checkOutput("rst clr_busy", 32'(clr_busy), 0);
    @(negedge pixel_clk);
    data_reset_n = 1'b1;
    #1;
    checkOutput("post-rst grant addr", 32'(ram_addr), 32'h003);
    checkOutput("post-rst grant ack", 32'(cpu_ack), 0);
    @(negedge pixel_clk); #1;
    checkOutput("post-rst wait ack", 32'(cpu_ack), 0);
    @(negedge pixel_clk); #1;
    checkOutput("post-rst ack", 32'(cpu_ack), 1);
    checkOutput("post-rst rdata", 32'(cpu_rdata), 32'hA003);
    checkOutput("post-rst ack no regrant", 32'(ram_addr), 0);
    @(negedge pixel_clk);
    cpu_req = 1'b0;
    #1;
    checkOutput("post-rst ack pulse", 32'(cpu_ack), 0);

    // df da rq we ca wd | eWe eA eWd ack err rdata valid dispData
    vecs.push_back(mk(0, 12'h000, 1, 1, 12'h005, 16'h1F41, 1, 12'h005, 16'h1F41, 0, 0, 16'hA003, 0, 16'h0000));
    vecs.push_back(mk(0, 12'h000, 1, 1, 12'h005, 16'h1F41, 0, 12'h000, 16'h0000, 0, 0, 16'hA003, 0, 16'h0000));
    vecs.push_back(mk(0, 12'h000, 1, 1, 12'h005, 16'h1F41, 0, 12'h000, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(0, 12'h000, 1, 0, 12'h005, 16'h0000, 0, 12'h005, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(0, 12'h000, 1, 0, 12'h005, 16'h0000, 0, 12'h000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 12'h010, 1, 0, 12'h005, 16'h0000, 0, 12'h010, 16'h0000, 1, 0, 16'h1F41, 0, 16'h0000));
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h000, 16'h0000, 0, 12'h000, 16'h0000, 0, 0, 16'h1F41, 0, 16'h0000));
    vecs.push_back(mk(0, 12'h000, 1, 1, 12'h7D0, 16'hBEEF, 0, 12'h7D0, 16'h0000, 0, 0, 16'h1F41, 1, 16'hA010));
    vecs.push_back(mk(0, 12'h000, 1, 1, 12'h7D0, 16'hBEEF, 0, 12'h000, 16'h0000, 0, 0, 16'h1F41, 0, 16'hA010));
    vecs.push_back(mk(0, 12'h000, 1, 1, 12'h7D0, 16'hBEEF, 0, 12'h000, 16'h0000, 1, 1, 16'h0000, 0, 16'hA010));
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h000, 16'h0000, 0, 12'h000, 16'h0000, 0, 0, 16'h0000, 0, 16'hA010));
    vecs.push_back(mk(1, 12'h020, 1, 0, 12'h005, 16'h0000, 0, 12'h020, 16'h0000, 0, 0, 16'h0000, 0, 16'hA010));
    vecs.push_back(mk(1, 12'h021, 1, 0, 12'h005, 16'h0000, 0, 12'h021, 16'h0000, 0, 0, 16'h0000, 0, 16'hA010));
    vecs.push_back(mk(0, 12'h000, 1, 0, 12'h005, 16'h0000, 0, 12'h005, 16'h0000, 0, 0, 16'h0000, 1, 16'hA020));
    vecs.push_back(mk(0, 12'h000, 1, 0, 12'h005, 16'h0000, 0, 12'h000, 16'h0000, 0, 0, 16'h0000, 1, 16'hA021));
    vecs.push_back(mk(0, 12'h000, 1, 0, 12'h005, 16'h0000, 0, 12'h000, 16'h0000, 1, 0, 16'h1F41, 0, 16'hA021));
    vecs.push_back(mk(0, 12'h000, 0, 0, 12'h000, 16'h0000, 0, 12'h000, 16'h0000, 0, 0, 16'h1F41, 0, 16'hA021));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d ram_we", i), 32'(ram_we), 32'(vecs[i].expWe));
      checkOutput($sformatf("vec%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].expAddr));
      if (vecs[i].expWe)
        checkOutput($sformatf("vec%0d ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].expWdata));
      checkOutput($sformatf("vec%0d cpu_ack", i), 32'(cpu_ack), 32'(vecs[i].expAck));
      checkOutput($sformatf("vec%0d cpu_err", i), 32'(cpu_err), 32'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].expRdata));
      checkOutput($sformatf("vec%0d disp_valid", i), 32'(disp_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d disp_data", i), 32'(disp_data), 32'(vecs[i].expDispData));
      checkOutput($sformatf("vec%0d clr_busy", i), 32'(clr_busy), 0);
    end
    checkOutput("oor write blocked", 32'(mem[12'h7D0]), 32'h0000A7D0);

    // Ten back-to-back display fetches starve a pending CPU read.
    validCount = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge pixel_clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h006;
      disp_fetch = (i < 10);
      disp_addr = 12'h100 + 12'(i);
      #1;
      if (disp_valid) validCount++;
      if (i < 10) checkOutput($sformatf("starve%0d ram_addr", i), 32'(ram_addr), 32'h100 + 32'(i));
      if (i == 10) checkOutput("starve grant addr", 32'(ram_addr), 32'h006);
      if (i == 11) checkOutput("starve wait ack", 32'(cpu_ack), 0);
      if (i == 12) begin
        checkOutput("starve ack", 32'(cpu_ack), 1);
        checkOutput("starve rdata", 32'(cpu_rdata), 32'hA006);
        checkOutput("starve last disp_data", 32'(disp_data), 32'hA109);
      end
    end
    checkOutput("starve valid pulses", 32'(validCount), 32'd10);
    @(negedge pixel_clk);
    cpu_req = 1'b0; disp_fetch = 1'b0;

    runClear(16'h0720, 1'b0, 2000);
    runClear(16'h0E41, 1'b1, 2286);

    // Clear and CPU request arrive together; a second start mid-clear is ignored.
    @(negedge pixel_clk);
    clr_start = 1'b1; clr_value = 16'h1111;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h009; cpu_wdata = 16'h5555;
    #1;
    checkOutput("clr beats cpu ram_we", 32'(ram_we), 0);
    checkOutput("clr beats cpu ram_addr", 32'(ram_addr), 0);
    @(negedge pixel_clk);
    busyCount = 0; acks = 0; badFill = 0;
    for (int k = 0; k < 3000; k++) begin
      clr_start = (k == 100);
      clr_value = 16'h2222;
      #1;
      if (!clr_busy) break;
      busyCount++;
      if (cpu_ack) acks++;
      if (ram_we && ram_wdata != 16'h1111) badFill++;
      @(negedge pixel_clk);
    end
    clr_start = 1'b0;
    checkOutput("restart ignored busy", 32'(busyCount), 32'd2000);
    checkOutput("no ack while busy", 32'(acks), 0);
    checkOutput("fill not relatched", 32'(badFill), 0);
    checkOutput("cpu grant at busy fall we", 32'(ram_we), 1);
    checkOutput("cpu grant at busy fall addr", 32'(ram_addr), 32'h009);
    @(negedge pixel_clk); #1;
    checkOutput("after clr wait ack", 32'(cpu_ack), 0);
    @(negedge pixel_clk); #1;
    checkOutput("after clr ack", 32'(cpu_ack), 1);
    @(negedge pixel_clk);
    cpu_req = 1'b0;
    #1;
    checkOutput("after clr cpu write", 32'(mem[9]), 32'h5555);
    checkOutput("after clr neighbour", 32'(mem[10]), 32'h1111);

    // Clear requested during CPU_WAIT is deferred until after the ack.
    @(negedge pixel_clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h00A;
    #1;
    checkOutput("pend grant addr", 32'(ram_addr), 32'h00A);
    @(negedge pixel_clk);
    clr_start = 1'b1; clr_value = 16'h3333;
    #1;
    checkOutput("pend wait busy", 32'(clr_busy), 0);
    @(negedge pixel_clk);
    clr_start = 1'b0; clr_value = 16'h0000;
    #1;
    checkOutput("pend ack", 32'(cpu_ack), 1);
    checkOutput("pend rdata", 32'(cpu_rdata), 32'h1111);
    checkOutput("pend ack busy", 32'(clr_busy), 0);
    @(negedge pixel_clk);
    cpu_req = 1'b0;
    #1;
    checkOutput("pend busy", 32'(clr_busy), 1);
    checkOutput("pend first write we", 32'(ram_we), 1);
    checkOutput("pend first write addr", 32'(ram_addr), 0);
    checkOutput("pend first write data", 32'(ram_wdata), 32'h3333);
    busyCount = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!clr_busy) break;
      busyCount++;
      @(negedge pixel_clk);
      #1;
    end
    checkOutput("pend busy cycles", 32'(busyCount), 32'd2000);

    // Reset in the middle of a CPU access: no ack may follow.
    @(negedge pixel_clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h00B; cpu_wdata = 16'h7777;
    #1;
    checkOutput("abort grant we", 32'(ram_we), 1);
    @(negedge pixel_clk);
    data_reset_n = 1'b0;
    cpu_req = 1'b0;
    @(negedge pixel_clk);
    data_reset_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (cpu_ack) acks++;
      @(negedge pixel_clk);
    end
    checkOutput("abort no ack", 32'(acks), 0);
    checkOutput("abort busy", 32'(clr_busy), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
